vga_timing_gen: RTL

Parametrised VGA raster timing generator for the video card. Replaces the fixed-mode free-running sync counters with an enable-qualified horizontal/vertical counter pair. It is configurable per axis for active, front-porch, sync and back-porch lengths and for sync polarity. It produces registered `h_sync`/`v_sync`, data-enable, blanking, pixel coordinates, line/frame strobes and a frame counter for the pixel fetch path.

---
 rtl/vga_timing_pkg.sv | 41 ++++
 rtl/vga_timing_axis.sv | 74 +++++++
 rtl/vga_timing_gen.sv | 111 +++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared definitions for the VGA raster timing generator.
//   - axis_timing_t : per-axis timing record (active/fp/sync/bp lengths, sync polarity)
//   - vga_mode_t    : horizontal + vertical timing pair
//   - MODE_640x480_60, MODE_800x600_60 : standard mode constants
//   - axis_total()  : total count of one axis
//   - min_cnt_w()   : minimum counter width able to hold total-1
package vga_timing_pkg;

    typedef struct packed {
        int   active;
        int   fp;
        int   sync;
        int   bp;
        logic pol;
    } axis_timing_t;

    typedef struct packed {
        axis_timing_t h;
        axis_timing_t v;
    } vga_mode_t;

    localparam vga_mode_t MODE_640x480_60 = '{
        h: '{active: 640, fp: 16, sync: 96,  bp: 48, pol: 1'b0},
        v: '{active: 480, fp: 10, sync: 2,   bp: 33, pol: 1'b0}
    };

    localparam vga_mode_t MODE_800x600_60 = '{
        h: '{active: 800, fp: 40, sync: 128, bp: 88, pol: 1'b1},
        v: '{active: 600, fp: 1,  sync: 4,   bp: 23, pol: 1'b1}
    };

    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int min_cnt_w(input int total);
        return (total <= 2) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/vga_timing_axis.sv
// vga_timing_axis: one raster axis (horizontal or vertical).
//   clk, rst   : clock, asynchronous active-high reset
//   step       : advance the counter by one on this clk edge
//   count      : current position (registered)
//   blank      : count >= ACTIVE (registered)
//   sync       : POL while count is inside the sync region, else ~POL (registered)
//   blank_next : value blank takes on the next edge (lets the top register de
//                in the same cycle as the blanks)
//   wrap       : count sits at TOTAL-1, i.e. the next step returns to 0
module vga_timing_axis
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter bit POL    = 1'b0,
    parameter int CNT_W  = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    output logic [CNT_W-1:0] count,
    output logic             blank,
    output logic             sync,
    output logic             blank_next,
    output logic             wrap
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

    if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_region
        $error("vga_timing_axis: every region length must be at least 1");
    end
    if (CNT_W < min_cnt_w(TOTAL)) begin : g_bad_width
        $error("vga_timing_axis: CNT_W too narrow for TOTAL-1");
    end

    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACT_END  = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_BEG = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(ACTIVE + FP + SYNC - 1);

    logic [CNT_W-1:0] count_next;
    logic             sync_next;

    assign wrap = (count == LAST);

    // Flags are decoded from the next count so they land on the same edge
    // as the count itself; without a step everything holds.
    always_comb begin
        count_next = count;
        blank_next = blank;
        sync_next  = sync;
        if (step) begin
            count_next = wrap ? '0 : count + 1'b1;
            blank_next = (count_next >= ACT_END);
            sync_next  = (count_next >= SYNC_BEG && count_next <= SYNC_END) ? POL : ~POL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= LAST;
            blank <= 1'b1;
            sync  <= ~POL;
        end else begin
            count <= count_next;
            blank <= blank_next;
            sync  <= sync_next;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
//   clk, rst    : clock, asynchronous active-high reset
//   en          : pixel-rate enable; counters advance only when en=1
//   h_sync      : horizontal sync, HS_POL when asserted
//   v_sync      : vertical sync, VS_POL when asserted
//   de          : data enable, 1 inside the visible region
//   h_blank     : x >= H_ACTIVE
//   v_blank     : y >= V_ACTIVE
//   x, y        : current pixel coordinates (unclamped)
//   line_start  : one-clk strobe on entry to x=0
//   frame_start : one-clk strobe on entry to (0,0)
//   frame_cnt   : completed-frame count, wraps modulo 2^FRAME_W
// All outputs are registered and describe the pixel at (x, y). Reset parks the
// raster on the last pixel so the first enabled edge presents (0,0).
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = 11,
    parameter int FRAME_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic               h_sync,
    output logic               v_sync,
    output logic               de,
    output logic               h_blank,
    output logic               v_blank,
    output logic [CNT_W-1:0]   x,
    output logic [CNT_W-1:0]   y,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    if (FRAME_W < 1) begin : g_bad_frame_w
        $error("vga_timing_gen: FRAME_W must be at least 1");
    end

    logic h_wrap;
    logic v_wrap;
    logic h_blank_next;
    logic v_blank_next;
    logic line_adv;
    logic frame_adv;
    logic started;

    assign line_adv  = en & h_wrap;
    assign frame_adv = line_adv & v_wrap;

    vga_timing_axis #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
        .POL(HS_POL), .CNT_W(CNT_W)
    ) u_h_axis (
        .clk        (clk),
        .rst        (rst),
        .step       (en),
        .count      (x),
        .blank      (h_blank),
        .sync       (h_sync),
        .blank_next (h_blank_next),
        .wrap       (h_wrap)
    );

    vga_timing_axis #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
        .POL(VS_POL), .CNT_W(CNT_W)
    ) u_v_axis (
        .clk        (clk),
        .rst        (rst),
        .step       (line_adv),
        .count      (y),
        .blank      (v_blank),
        .sync       (v_sync),
        .blank_next (v_blank_next),
        .wrap       (v_wrap)
    );

    // The wrap out of reset enters the first frame rather than completing
    // one, so 'started' keeps it from being counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
            started     <= 1'b0;
        end else begin
            de          <= ~h_blank_next & ~v_blank_next;
            line_start  <= line_adv;
            frame_start <= frame_adv;
            if (en) begin
                started <= 1'b1;
            end
            if (frame_adv && started) begin
                frame_cnt <= frame_cnt + FRAME_W'(1);
            end
        end
    end

endmodule
